// File: rtl/out_misr_checker.sv
// Response-side MISR checker: folds each valid DUT output beat into a 32-bit
// signature, skipping warm-up beats, then compares against a golden value.
module out_misr_checker #(
    parameter int          OUT_W = 412,
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      num_cycles,
    input  logic [7:0]       skip_cycles,
    input  logic [31:0]      expected_sig,
    input  logic             data_valid,
    input  logic [OUT_W-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [31:0]      signature,
    output logic [15:0]      sample_count
);

    localparam int N_CHUNK = (OUT_W + 31) / 32;
    localparam int PAD_W   = N_CHUNK * 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SKIP    = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]       r_state;
    logic [31:0]      r_sig;
    logic [15:0]      r_count;
    logic [7:0]       r_skip_cnt;
    logic [15:0]      r_num;
    logic [31:0]      r_expected;
    logic             r_pass;

    logic [PAD_W-1:0] w_padded;
    logic [31:0]      w_fold;
    logic [31:0]      w_sig_next;
    logic [15:0]      w_count_inc;

    // Zero-pad the bus to whole 32-bit chunks and XOR all chunks together.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_padded              = '0;
        w_padded[OUT_W-1:0]   = data_in;
        w_fold                = '0;
        for (int k = 0; k < N_CHUNK; k++) begin
            w_fold = w_fold ^ w_padded[32*k +: 32];
        end
    end

    assign w_sig_next  = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0) ^ w_fold;
    assign w_count_inc = r_count + 16'd1;

    // NOTE: state registers use non-blocking assignments so every update in a
    // cycle sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sig      <= SEED;
            r_count    <= '0;
            r_skip_cnt <= '0;
            r_num      <= '0;
            r_expected <= '0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // A load wins over any beat presented on the same cycle.
                    if (start) begin
                        r_sig      <= SEED;
                        r_count    <= '0;
                        r_skip_cnt <= skip_cycles;
                        r_num      <= num_cycles;
                        r_expected <= expected_sig;
                        r_pass     <= 1'b0;
                        if (skip_cycles != 8'd0) begin
                            r_state <= ST_SKIP;
                        end else if (num_cycles != 16'd0) begin
                            r_state <= ST_COLLECT;
                        end else begin
                            r_state <= ST_DONE;
                            r_pass  <= (SEED == expected_sig);
                        end
                    end
                end
                ST_SKIP: begin
                    if (data_valid) begin
                        r_skip_cnt <= r_skip_cnt - 8'd1;
                        if (r_skip_cnt == 8'd1) begin
                            if (r_num != 16'd0) begin
                                r_state <= ST_COLLECT;
                            end else begin
                                r_state <= ST_DONE;
                                r_pass  <= (r_sig == r_expected);
                            end
                        end
                    end
                end
                ST_COLLECT: begin
                    if (data_valid) begin
                        r_sig   <= w_sig_next;
                        r_count <= w_count_inc;
                        if (w_count_inc == r_num) begin
                            r_state <= ST_DONE;
                            r_pass  <= (w_sig_next == r_expected);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (r_state == ST_SKIP) || (r_state == ST_COLLECT);
    assign done         = (r_state == ST_DONE);
    assign pass         = r_pass;
    assign signature    = r_sig;
    assign sample_count = r_count;

endmodule
